keypad_scan_ctrl: RTL and testbench

- Sequences a 4x4 matrix keypad: drives one row low at a time, samples the columns, debounces per full scan frame, and emits one key code per press on a valid/ready handshake.
- Scan timing comes from an internal prescaler that produces a single-cycle enable tick. No derived clock is generated; the whole block runs on clock_in.
- Sits between the keypad pins and the keypad consumer logic.

---
 rtl/keypad_scan_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 matrix keypad scanner. Drives one row low at a time,
//            samples the columns, debounces over whole scan frames and
//            presents one key code per press on a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_in     in   1  system clock (the only clock in the block)
//   reset        in   1  asynchronous active-low reset
//   col_in       in   4  keypad columns, active-low, asynchronous
//   row_out      out  4  row drive, active-low, exactly one bit low
//   key_code     out  4  {row[1:0], col[1:0]} of the accepted key
//   key_valid    out  1  key_code holds an unconsumed press
//   key_ready    in   1  consumer accepts key_code with key_valid
//   key_held     out  1  a debounced key is currently down
//   overrun      out  1  sticky: a press was dropped (holding reg full)
//   overrun_clr  in   1  synchronous clear of overrun
// ============================================================================
module keypad_scan_ctrl #(
    parameter int INPUT_HZ        = 50000,
    parameter int SCAN_HZ         = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam logic [19:0] c_TICK_LAST = 20'(INPUT_HZ / SCAN_HZ - 1);
    localparam int          c_CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_DB_TGT = c_CNT_W'(DEBOUNCE_FRAMES);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_PRESS_DB = 2'd1;
    localparam logic [1:0] c_ST_HELD     = 2'd2;
    localparam logic [1:0] c_ST_REL_DB   = 2'd3;

    logic [3:0]         r_col_meta;
    logic [3:0]         r_col_sync;
    logic [19:0]        r_presc;
    logic [1:0]         r_row_idx;
    logic [3:0]         r_row_out;
    logic [2:0][3:0]    r_rows;       // latched columns of rows 0..2
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_cand;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_held;
    logic               r_overrun;

    logic               w_tick;
    logic               w_frame_done;
    logic [1:0]         w_row_idx_nxt;
    logic [15:0]        w_low;
    logic [4:0]         w_low_cnt;
    logic [3:0]         w_key;
    logic               w_none;
    logic               w_single;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         w_cand_nxt;
    logic               w_emit;

    assign w_tick        = (r_presc == c_TICK_LAST);
    assign w_frame_done  = w_tick && (r_row_idx == 2'd3);
    assign w_row_idx_nxt = r_row_idx + 2'd1;

    // Row 3 is classified straight from the synchronizer on the tick that
    // would latch it, so a frame needs no extra cycle to complete.
    assign w_low = ~{r_col_sync, r_rows[2], r_rows[1], r_rows[0]};

    always_comb begin
        w_low_cnt = 5'd0;
        w_key     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_low[i]) begin
                w_low_cnt = w_low_cnt + 5'd1;
                w_key     = 4'(i);
            end
        end
    end

    assign w_none   = (w_low_cnt == 5'd0);
    assign w_single = (w_low_cnt == 5'd1);

    // Synchronizer, prescaler and row scan.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
            r_presc    <= '0;
            r_row_idx  <= 2'd0;
            r_row_out  <= 4'b1110;
            r_rows     <= '1;
        end else begin
            r_col_meta <= col_in;
            r_col_sync <= r_col_meta;
            if (w_tick) begin
                r_presc   <= '0;
                r_row_idx <= w_row_idx_nxt;
                r_row_out <= ~(4'b0001 << w_row_idx_nxt);
                if (r_row_idx != 2'd3) begin
                    r_rows[r_row_idx] <= r_col_sync;
                end
            end else begin
                r_presc <= r_presc + 20'd1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_cand     <= 4'd0;
            r_key_held <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cand     <= w_cand_nxt;
            r_key_held <= (w_state_nxt == c_ST_HELD) || (w_state_nxt == c_ST_REL_DB);
        end
    end

    // Debounce next state; everything moves only on frame-complete ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_emit      = 1'b0;
        if (w_frame_done) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_key;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_emit      = 1'b1;
                            w_state_nxt = c_ST_HELD;
                        end else begin
                            w_cnt_nxt   = c_CNT_W'(1);
                            w_state_nxt = c_ST_PRESS_DB;
                        end
                    end
                end
                c_ST_PRESS_DB: begin
                    if (w_single && (w_key == r_cand)) begin
                        if ((r_cnt + c_CNT_W'(1)) == c_DB_TGT) begin
                            w_emit      = 1'b1;
                            w_state_nxt = c_ST_HELD;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_key;
                        w_cnt_nxt  = c_CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                c_ST_HELD: begin
                    // No rollover: only an empty frame starts the release.
                    if (w_none) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_cnt_nxt   = c_CNT_W'(1);
                            w_state_nxt = c_ST_REL_DB;
                        end
                    end
                end
                c_ST_REL_DB: begin
                    if (w_none) begin
                        if ((r_cnt + c_CNT_W'(1)) == c_DB_TGT) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        end
                    end else if (w_single && (w_key == r_cand)) begin
                        w_state_nxt = c_ST_HELD;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Single-entry holding register. A press arriving while the entry is
    // full and not being consumed is dropped and flagged.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_emit && (!r_key_valid || key_ready)) begin
                r_key_code  <= w_cand_nxt;
                r_key_valid <= 1'b1;
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
            if (w_emit && r_key_valid && !key_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign row_out   = r_row_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Bench for keypad_scan_ctrl. A keypad model turns a set of
//            pressed keys into column levels from the driven row; a frame
//            level reference model predicts presses into a scoreboard queue
//            that a monitor drains on every accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int c_DB    = 3;
    localparam int c_FRAME = 32;   // 4 rows x TICK_DIV (16/2)

    logic       clock_in    = 1'b0;
    logic       reset       = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready   = 1'b1;
    logic       key_held;
    logic       overrun;
    logic       overrun_clr = 1'b0;

    logic [15:0] pressed    = 16'h0000;   // bit {r,c} = key held down
    int          ready_mode = 0;          // 0: high, 1: low, 2: random
    int          clr_mode   = 0;          // 0: low, 1: high, 2: random pulses

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0] q[$];
    bit         accepted;
    int         streak;
    int         rel;
    logic [3:0] cand;
    bit         exp_ov;
    int         k;

    always #5 clock_in = ~clock_in;

    keypad_scan_ctrl #(
        .INPUT_HZ        (16),
        .SCAN_HZ         (2),
        .DEBOUNCE_FRAMES (c_DB)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // Passive keypad: a pressed key shorts its column to the driven row.
    always_comb begin
        col_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", nm, act, exp, k, $time);
        end
    endtask

    function automatic logic [15:0] kb(input int code);
        return 16'(1) << code;
    endfunction

    task automatic emit_key(input logic [3:0] code);
        if (q.size() == 0) q.push_back(code);
        else exp_ov = 1'b1;
    endtask

    // A press is accepted after c_DB consecutive frames showing the same
    // single key; it is released after c_DB consecutive empty frames.
    task automatic frame_model(input logic [15:0] p);
        int         n;
        logic [3:0] key;
        n   = $countones(p);
        key = 4'd0;
        for (int i = 0; i < 16; i++) if (p[i]) key = 4'(i);
        if (!accepted) begin
            if (n == 1) begin
                if (streak > 0 && key == cand) streak++;
                else begin
                    cand   = key;
                    streak = 1;
                end
            end else begin
                streak = 0;
            end
            if (streak >= c_DB) begin
                emit_key(cand);
                accepted = 1'b1;
                streak   = 0;
                rel      = 0;
            end
        end else begin
            if (n == 0) rel++;
            else rel = 0;
            if (rel >= c_DB) begin
                accepted = 1'b0;
                rel      = 0;
            end
        end
    endtask

    // Monitor: one step per clock, 1 time unit after the edge.
    always begin
        @(posedge clock_in);
        #1;
        if (!reset) begin
            k = 0;
            q.delete();
            accepted = 1'b0;
            streak   = 0;
            rel      = 0;
            cand     = 4'd0;
            exp_ov   = 1'b0;
            chk("rst_row", row_out, 4'b1110);
            chk("rst_valid", {3'b0, key_valid}, 4'd0);
            chk("rst_held", {3'b0, key_held}, 4'd0);
        end else begin
            k++;
            if (q.size() != 0 && key_ready) void'(q.pop_front());
            if (overrun_clr) exp_ov = 1'b0;
            if (k % c_FRAME == 0) frame_model(pressed);
            chk("row_out", row_out, ~(4'b0001 << ((k / 8) % 4)));
            chk("key_valid", {3'b0, key_valid}, {3'b0, q.size() != 0});
            if (q.size() != 0) chk("key_code", key_code, q[0]);
            chk("key_held", {3'b0, key_held}, {3'b0, accepted});
            chk("overrun", {3'b0, overrun}, {3'b0, exp_ov});
        end
    end

    // Consumer side driver, applied mid-cycle.
    always begin
        @(posedge clock_in);
        #5;
        case (ready_mode)
            0:       key_ready = 1'b1;
            1:       key_ready = 1'b0;
            default: key_ready = 1'($urandom_range(0, 1));
        endcase
        case (clr_mode)
            0:       overrun_clr = 1'b0;
            1:       overrun_clr = 1'b1;
            default: overrun_clr = ($urandom_range(0, 19) == 0);
        endcase
    end

    // Hold a key pattern for n whole frames (called at frame start + 3).
    task automatic frames(input logic [15:0] p, input int n);
        pressed = p;
        repeat (c_FRAME * n) @(posedge clock_in);
        #3;
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        #1;
        chk("arst_row", row_out, 4'b1110);
        chk("arst_code", key_code, 4'd0);
        chk("arst_valid", {3'b0, key_valid}, 4'd0);
        chk("arst_held", {3'b0, key_held}, 4'd0);
        chk("arst_ovr", {3'b0, overrun}, 4'd0);
        pressed = 16'h0000;
        repeat (hold) @(posedge clock_in);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        int         seg_frames;
        int         sel;
        logic [3:0] a;
        logic [3:0] last;

        repeat (3) @(posedge clock_in);
        #3;
        reset = 1'b1;

        // Idle scanning
        frames(16'h0000, 2);

        // Key 9 (row 2, col 1) held then released
        frames(kb(9), 5);
        frames(16'h0000, 4);

        // Bounce: 2 frames, gap, 3 frames
        frames(kb(9), 2);
        frames(16'h0000, 1);
        frames(kb(9), 3);
        frames(16'h0000, 4);

        // Two keys together, then one released
        frames(kb(0) | kb(5), 6);
        frames(kb(0), 3);
        frames(16'h0000, 4);

        // Second press dropped while the consumer stalls
        ready_mode = 1;
        frames(kb(3), 3);
        frames(16'h0000, 3);
        frames(kb(12), 3);
        frames(16'h0000, 3);
        chk("ovr_code", key_code, 4'h3);
        chk("ovr_flag", {3'b0, overrun}, 4'd1);
        clr_mode = 1;
        @(posedge clock_in);
        #3;
        clr_mode = 0;
        repeat (4) @(posedge clock_in);
        #3;
        chk("ovr_cleared", {3'b0, overrun}, 4'd0);
        ready_mode = 0;
        repeat (c_FRAME - 5) @(posedge clock_in);
        #3;

        // Reset while debouncing a press
        frames(kb(6), 2);
        pressed = kb(6);
        repeat (10) @(posedge clock_in);
        #3;
        do_reset(4);
        frames(16'h0000, 4);

        // Reset while a code is pending
        ready_mode = 1;
        frames(kb(10), 3);
        repeat (2) @(posedge clock_in);
        #3;
        chk("pend_valid", {3'b0, key_valid}, 4'd1);
        do_reset(3);
        ready_mode = 0;
        frames(16'h0000, 4);

        // Randomized patterns with a random consumer
        ready_mode = 2;
        clr_mode   = 2;
        last       = 4'd0;
        for (int s = 0; s < 50; s++) begin
            seg_frames = $urandom_range(1, 5);
            sel        = $urandom_range(0, 9);
            if (sel < 3) begin
                frames(16'h0000, seg_frames);
            end else if (sel < 8) begin
                a = ($urandom_range(0, 1) == 0) ? last : 4'($urandom_range(0, 15));
                last = a;
                frames(kb(int'(a)), seg_frames);
            end else begin
                a = 4'($urandom_range(0, 15));
                frames(kb(int'(a)) | kb(int'(a + 4'($urandom_range(1, 15)))), seg_frames);
            end
        end
        ready_mode = 0;
        clr_mode   = 0;
        frames(16'h0000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
